// File: rtl/audio_fir_pkg.sv
// Shared types and constants for the audio FIR core and its register block.
package audio_fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    localparam int FIR_NUM_TAPS = 32;
    localparam int FIR_DATA_W   = 16;
    localparam int FIR_COEF_W   = 16;

    // Largest positive Q1.15 value, used as "unity" for tap 0 after reset
    localparam logic [15:0] FIR_COEF_UNITY = 16'h7FFF;

    // Register offsets shared with the AXI4-Lite FIR register block
    localparam logic [11:0] FIR_REG_COEF_BASE = 12'h000;
    localparam logic [11:0] FIR_REG_COMMIT    = 12'h400;
    localparam logic [11:0] FIR_REG_BYPASS    = 12'h404;

endpackage

// File: rtl/audio_fir_core_if.sv
// Sample stream and coefficient control bundle for audio_fir_core.
// AUDIO_FIR_SATURATE_EN adds sat_flag_out.
interface audio_fir_core_if #(
    parameter int NUM_TAPS = 32,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16
);
    localparam int AW = $clog2(NUM_TAPS);

    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid_in;
    logic                     sample_ready_out;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_valid_out;
    logic                     coef_wr_en_in;
    logic [AW-1:0]            coef_wr_addr_in;
    logic signed [COEF_W-1:0] coef_wr_data_in;
    logic                     coef_commit_in;
    logic                     bypass_in;
    logic                     busy_out;
`ifdef AUDIO_FIR_SATURATE_EN
    logic                     sat_flag_out;
`endif

    modport master (
        output sample_in, sample_valid_in, coef_wr_en_in, coef_wr_addr_in,
               coef_wr_data_in, coef_commit_in, bypass_in,
        input  sample_ready_out, sample_out, sample_valid_out, busy_out
`ifdef AUDIO_FIR_SATURATE_EN
        , input sat_flag_out
`endif
    );

    modport slave (
        input  sample_in, sample_valid_in, coef_wr_en_in, coef_wr_addr_in,
               coef_wr_data_in, coef_commit_in, bypass_in,
        output sample_ready_out, sample_out, sample_valid_out, busy_out
`ifdef AUDIO_FIR_SATURATE_EN
        , output sat_flag_out
`endif
    );

endinterface

// File: rtl/audio_fir_coef_bank.sv
// Shadow/active coefficient banks. Writes land in shadow; a commit copies
// shadow to active only while the core is idle, otherwise it waits.
module audio_fir_coef_bank
    import audio_fir_pkg::*;
#(
    parameter int NUM_TAPS = FIR_NUM_TAPS,
    parameter int COEF_W   = FIR_COEF_W,
    localparam int AW      = $clog2(NUM_TAPS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     idle,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     commit,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [COEF_W-1:0] rd_data
);
    localparam logic signed [COEF_W-1:0] UNITY = {1'b0, {(COEF_W-1){1'b1}}};

    logic signed [COEF_W-1:0] shadow [NUM_TAPS];
    logic signed [COEF_W-1:0] active [NUM_TAPS];
    logic                     pending;
    logic                     copy;

    // A pending commit is consumed at the first idle edge, so a sample
    // accepted on that same edge already sees the new coefficients.
    assign copy    = idle && (commit || pending);
    assign rd_data = active[rd_addr];

    // Bank registers; copy reads shadow before this edge's write lands
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow[i] <= (i == 0) ? UNITY : '0;
                active[i] <= (i == 0) ? UNITY : '0;
            end
            pending <= 1'b0;
        end else begin
            if (copy)
                active <= shadow;
            pending <= !idle && (commit || pending);
            if (wr_en)
                shadow[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/audio_fir_core.sv
// Time-multiplexed single-MAC FIR: one tap per clock, one output per input.
// Optional clamp of the rounded result: define AUDIO_FIR_SATURATE_EN.
module audio_fir_core
    import audio_fir_pkg::*;
#(
    parameter int NUM_TAPS = FIR_NUM_TAPS,
    parameter int DATA_W   = FIR_DATA_W,
    parameter int COEF_W   = FIR_COEF_W,
    parameter int ACC_W    = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
    input logic            clk_in,
    input logic            rst_in,
    audio_fir_core_if.slave bus
);
    localparam int AW = $clog2(NUM_TAPS);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_W - 2);

    fir_state_t state, state_nxt;

    logic [AW-1:0]                   wr_ptr, k;
    logic signed [ACC_W-1:0]         acc, acc_nxt;
    logic signed [DATA_W-1:0]        hist [NUM_TAPS];
    logic signed [DATA_W-1:0]        smp_lat, res, sample_q;
    logic signed [COEF_W-1:0]        coef;
    logic signed [DATA_W+COEF_W-1:0] prod;
    logic                            byp_lat, ovf, sat_q;
    logic                            accept, last_tap;

    audio_fir_coef_bank #(.NUM_TAPS(NUM_TAPS), .COEF_W(COEF_W)) u_bank (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .idle   (state == IDLE),
        .wr_en  (bus.coef_wr_en_in),
        .wr_addr(bus.coef_wr_addr_in),
        .wr_data(bus.coef_wr_data_in),
        .commit (bus.coef_commit_in),
        .rd_addr(k),
        .rd_data(coef)
    );

    assign accept   = (state == IDLE) && bus.sample_valid_in;
    assign last_tap = (k == AW'(NUM_TAPS - 1));
    assign prod     = coef * hist[wr_ptr - k];
    assign acc_nxt  = acc + ACC_W'(prod);

`ifdef AUDIO_FIR_SATURATE_EN
    localparam int SW = ACC_W - COEF_W + 1;
    logic signed [SW-1:0] scaled;
    assign scaled = SW'((acc_nxt + HALF) >>> (COEF_W - 1));
    // Out of range when the bits above the DATA_W sign bit disagree with it
    assign ovf = !((&scaled[SW-1:DATA_W-1]) || !(|scaled[SW-1:DATA_W-1]));
    assign res = !ovf ? scaled[DATA_W-1:0] :
                 scaled[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    assign bus.sat_flag_out = sat_q && (state == OUT);
`else
    assign res = DATA_W'((acc_nxt + HALF) >>> (COEF_W - 1));
    assign ovf = 1'b0;
`endif

    assign bus.sample_ready_out = (state == IDLE);
    assign bus.busy_out         = (state != IDLE);
    assign bus.sample_valid_out = (state == OUT);
    assign bus.sample_out       = sample_q;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept -> NUM_TAPS MAC cycles -> one OUT cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: history write on accept, accumulate, result on the last tap
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            k        <= '0;
            acc      <= '0;
            smp_lat  <= '0;
            byp_lat  <= 1'b0;
            sample_q <= '0;
            sat_q    <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) hist[i] <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    hist[wr_ptr] <= bus.sample_in;
                    smp_lat      <= bus.sample_in;
                    byp_lat      <= bus.bypass_in;
                    acc          <= '0;
                    k            <= '0;
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + 1'b1;
                    if (last_tap) begin
                        sample_q <= byp_lat ? smp_lat : res;
                        sat_q    <= !byp_lat && ovf;
                    end
                end
                OUT:     wr_ptr <= wr_ptr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_fir_core.sv
// Self-checking bench for audio_fir_core: directed scenarios plus random
// traffic, all compared against a transaction-level filter model.
module tb_audio_fir_core;
    import audio_fir_pkg::*;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    audio_fir_core_if #(.NUM_TAPS(N), .DATA_W(DW), .COEF_W(CW)) bus ();

    audio_fir_core #(.NUM_TAPS(N), .DATA_W(DW), .COEF_W(CW)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: newest sample at m_hist[0]
    int          m_hist [N];
    int          m_act  [N];
    int          m_shd  [N];
    bit          m_pend;
    int          m_ph;        // 0 idle, 1..N MAC, N+1 output cycle
    logic [15:0] m_exp;
    bit          m_exp_sat;

    int          cyc, acc_cyc, pulse_cyc, n_pulse;
    logic [15:0] last_out;
    bit          last_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_ph = 0;
        m_pend = 0;
        for (int j = 0; j < N; j++) begin
            m_hist[j] = 0;
            m_act[j]  = (j == 0) ? int'(FIR_COEF_UNITY) : 0;
            m_shd[j]  = m_act[j];
        end
    endtask

    // Dot product, round half up, then clamp or wrap to 16 bits
    task automatic m_filter();
        longint s = 0;
        longint r;
        for (int j = 0; j < N; j++) s += longint'(m_act[j]) * longint'(m_hist[j]);
        r = (s + 16384) >>> 15;
        m_exp_sat = 0;
`ifdef AUDIO_FIR_SATURATE_EN
        if (r > 32767)       begin r = 32767;  m_exp_sat = 1; end
        else if (r < -32768) begin r = -32768; m_exp_sat = 1; end
`endif
        m_exp = r[15:0];
    endtask

    task automatic model_step();
        if (rst_in) begin
            m_reset();
        end else begin
            if (bus.coef_commit_in) m_pend = 1;
            if (m_ph == 0 && m_pend) begin
                m_act  = m_shd;
                m_pend = 0;
            end
            if (bus.coef_wr_en_in) m_shd[bus.coef_wr_addr_in] = int'(bus.coef_wr_data_in);
            if (m_ph == 0) begin
                if (bus.sample_valid_in) begin
                    for (int j = N - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
                    m_hist[0] = int'(bus.sample_in);
                    if (bus.bypass_in) begin
                        m_exp = bus.sample_in;
                        m_exp_sat = 0;
                    end else begin
                        m_filter();
                    end
                    m_ph = 1;
                end
            end else begin
                m_ph = (m_ph == N + 1) ? 0 : m_ph + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ready", bus.sample_ready_out, m_ph == 0);
        chk("busy", bus.busy_out, m_ph != 0);
        chk("valid", bus.sample_valid_out, m_ph == N + 1);
`ifdef AUDIO_FIR_SATURATE_EN
        chk("sat", bus.sat_flag_out, (m_ph == N + 1) && m_exp_sat);
        last_sat = bus.sat_flag_out;
`endif
        if (m_ph == N + 1) begin
            chk("out", $unsigned(bus.sample_out), m_exp);
            last_out  = bus.sample_out;
            pulse_cyc = cyc;
        end
        if (bus.sample_valid_out) n_pulse++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        model_step();
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        chk("rst_out", $unsigned(bus.sample_out), 0);
        chk("rst_ready", bus.sample_ready_out, 1);
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input bit byp);
        bit ok = 0;
        bus.sample_in = x;
        bus.bypass_in = byp;
        bus.sample_valid_in = 1'b1;
        for (int t = 0; t < 4 * N && !ok; t++) begin
            ok = bus.sample_ready_out;
            tick();
            if (ok) acc_cyc = cyc;
        end
        bus.sample_valid_in = 1'b0;
        bus.bypass_in = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Accept edge is cycle 0; the pulse cycle (N+1) starts at edge N
    task automatic drain();
        for (int t = 0; t < 4 * N && m_ph != 0; t++) tick();
        if (m_ph != 0) chk("drain_timeout", 0, 1);
        chk("latency", pulse_cyc - acc_cyc, N);
    endtask

    task automatic run(input logic [15:0] x, input bit byp);
        send(x, byp);
        drain();
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d, input bit cm);
        bus.coef_wr_en_in   = 1'b1;
        bus.coef_wr_addr_in = a[2:0];
        bus.coef_wr_data_in = d;
        bus.coef_commit_in  = cm;
        tick();
        bus.coef_wr_en_in   = 1'b0;
        bus.coef_commit_in  = 1'b0;
    endtask

    task automatic commit();
        bus.coef_commit_in = 1'b1;
        tick();
        bus.coef_commit_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mavg [6];
        int p0, nacc;
        mavg = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1000, 16'h1000};
        bus.sample_in = '0; bus.sample_valid_in = 0; bus.bypass_in = 0;
        bus.coef_wr_en_in = 0; bus.coef_wr_addr_in = '0; bus.coef_wr_data_in = '0;
        bus.coef_commit_in = 0;
        cyc = 0; n_pulse = 0; acc_cyc = 0; pulse_cyc = 0; last_out = '0; last_sat = 0;
        m_reset();
        @(negedge clk_in);
        do_reset();

        // Impulse through default coefficients
        run(16'h4000, 0); chk("imp0", last_out, 16'h4000);
        run(16'h0000, 0); chk("imp1", last_out, 16'h0000);

        // Four-tap moving average
        do_reset();
        for (int j = 0; j < 4; j++) wr_coef(j, 16'h2000, 0);
        commit();
        for (int i = 0; i < 6; i++) begin
            run(16'h1000, 0);
            chk("mavg", last_out, mavg[i]);
        end

        // Commit mid-sample only affects the next sample
        do_reset();
        send(16'h2000, 0);
        tick();
        wr_coef(0, 16'h4000, 0);
        commit();
        drain(); chk("cmt_old", last_out, 16'h2000);
        run(16'h2000, 0); chk("cmt_new", last_out, 16'h1000);
        // Write and commit on the same idle edge: commit takes the old shadow
        wr_coef(0, 16'h1000, 1);
        run(16'h2000, 0); chk("simul_old", last_out, 16'h1000);
        commit();
        run(16'h2000, 0); chk("simul_new", last_out, 16'h0400);

        // Overflow
        do_reset();
        for (int j = 0; j < 4; j++) wr_coef(j, 16'h7FFF, 0);
        commit();
        for (int i = 0; i < 4; i++) run(16'h7FFF, 0);
`ifdef AUDIO_FIR_SATURATE_EN
        chk("ovf", last_out, 16'h7FFF);
        chk("ovf_flag", last_sat, 1);
`else
        chk("ovf", last_out, 16'hFFF8);
`endif

        // Bypass, then un-bypass with arbitrary taps
        do_reset();
        for (int j = 0; j < N; j++) wr_coef(j, 16'($urandom), 0);
        commit();
        run(16'h8001, 1); chk("bypass", last_out, 16'h8001);
        for (int i = 0; i < 4; i++) run(16'($urandom), 1);
        for (int i = 0; i < 6; i++) run(16'($urandom), 0);

        // Continuous valid: one accept every N+2 cycles
        do_reset();
        p0 = n_pulse; nacc = 0;
        bus.sample_valid_in = 1'b1;
        for (int t = 0; t < 3 * (N + 2); t++) begin
            bus.sample_in = 16'($urandom);
            if (bus.sample_ready_out) nacc++;
            tick();
        end
        bus.sample_valid_in = 1'b0;
        chk("cont_accepts", nacc, 3);
        chk("cont_pulses", n_pulse - p0, 3);

        // Reset mid-MAC drops the sample and a pending commit
        send(16'($urandom), 0);
        tick();
        wr_coef(0, 16'h1000, 0);
        commit();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        p0 = n_pulse;
        for (int t = 0; t < N + 2; t++) tick();
        chk("rst_nopulse", n_pulse - p0, 0);
        chk("rst_ready_after", bus.sample_ready_out, 1);
        run(16'h4000, 0); chk("rst_imp0", last_out, 16'h4000);
        run(16'h0000, 0); chk("rst_imp1", last_out, 16'h0000);

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            bus.sample_valid_in = ($urandom_range(0, 1) == 1);
            bus.sample_in       = 16'($urandom);
            bus.bypass_in       = ($urandom_range(0, 4) == 0);
            bus.coef_wr_en_in   = ($urandom_range(0, 6) == 0);
            bus.coef_wr_addr_in = 3'($urandom_range(0, N - 1));
            bus.coef_wr_data_in = 16'($urandom);
            bus.coef_commit_in  = ($urandom_range(0, 19) == 0);
            rst_in              = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst_in = 1'b0;
        bus.sample_valid_in = 0; bus.coef_wr_en_in = 0; bus.coef_commit_in = 0;
        for (int t = 0; t < N + 3; t++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_fir_core.md
Name: audio_fir_core

Overview:
- Time-multiplexed, single-MAC FIR filter for the synth audio path.
- Sits directly downstream of the AXI4-Lite FIR register interface, which supplies coefficient writes, commit and bypass control.
- Filters the mono 16-bit sample stream from the synth mixer and hands results to the I2S/DAC output stage.
- Produces one filtered sample per accepted input; designed for audio rates that are far below the clock rate.

Parameters:
- NUM_TAPS, 32: number of filter taps; power of two, 4 to 128.
- DATA_W, 16: signed sample width.
- COEF_W, 16: signed coefficient width, Q1.(COEF_W-1).
- ACC_W, DATA_W+COEF_W+$clog2(NUM_TAPS): accumulator width.

Ports:
- clk_in, in, 1: system clock.
- rst_in, in, 1: synchronous active-high reset.
- sample_in, in, DATA_W: signed input sample.
- sample_valid_in, in, 1: input sample valid.
- sample_ready_out, out, 1: core can accept a sample.
- sample_out, out, DATA_W: signed filtered sample.
- sample_valid_out, out, 1: one-cycle pulse, sample_out valid.
- coef_wr_en_in, in, 1: write the shadow coefficient bank.
- coef_wr_addr_in, in, $clog2(NUM_TAPS): tap index.
- coef_wr_data_in, in, COEF_W: signed coefficient.
- coef_commit_in, in, 1: pulse; copy shadow bank to active bank.
- bypass_in, in, 1: pass input through unfiltered.
- busy_out, out, 1: FSM not in IDLE.

Behaviour:
- One clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset values:
  - sample_out=0, sample_valid_out=0, busy_out=0, sample_ready_out=1 (from the first cycle after reset deasserts).
  - Sample history cleared to 0; write pointer 0; accumulator 0.
  - Active and shadow coefficient banks: tap0=0x7FFF, all other taps 0.
- FSM states IDLE, MAC, OUT:
  - IDLE: sample_ready_out=1. On sample_valid_in&&sample_ready_out:
    - write sample_in to history[wr_ptr];
    - latch bypass_in and sample_in;
    - clear accumulator, tap counter k=0;
    - go to MAC.
  - MAC: each cycle acc += coef_active[k]*history[(wr_ptr-k) mod NUM_TAPS], full-precision signed arithmetic; k++. After k=NUM_TAPS-1, go to OUT.
  - OUT: register the result to sample_out; assert sample_valid_out for exactly 1 cycle; wr_ptr++ (wraps modulo NUM_TAPS); return to IDLE.
- Latency:
  - Accept edge is cycle 0; MAC occupies cycles 1..NUM_TAPS; sample_valid_out is high in cycle NUM_TAPS+1.
  - Next accept is possible in cycle NUM_TAPS+2.
  - sample_ready_out=0 in MAC and OUT.
- Result: (acc + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round-half-up, then reduced to DATA_W bits (see Optional Feature).
- Bypass: if latched bypass=1, sample_out is the latched input sample. Latency is unchanged. The history is still updated, so un-bypassing produces no transient gap.
- Coefficient writes: coef_wr_en_in writes only the shadow bank and is allowed in any state.
- Commit:
  - In IDLE, the copy happens at that edge, before any sample accepted on the same edge is processed.
  - In MAC or OUT, the commit is held pending and applied on the cycle of entering IDLE. It never changes coefficients mid-sample.
- Simultaneous events:
  - coef_wr_en_in and coef_commit_in on the same edge: the commit copies the old shadow value for that address; the new write lands in the shadow only.
  - sample_valid_out is never suppressed by a new input arriving.
- sample_valid_in while not ready: ignored. Upstream must hold the sample.
- Reset mid-MAC: abort immediately, apply all reset values, pending commit dropped, no output pulse.

Optional Feature:
- Macro AUDIO_FIR_SATURATE_EN.
- Defined: the rounded result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. An additional output sat_flag_out (1 bit) pulses together with sample_valid_out when clamping occurred; its reset value is 0.
- Undefined: the result is truncated to the low DATA_W bits (two's-complement wrap), and sat_flag_out does not exist.

Decomposition:
- Package audio_fir_pkg holds:
  - fir_state_t enum (IDLE, MAC, OUT);
  - default NUM_TAPS, DATA_W and COEF_W constants;
  - the unity coefficient constant 0x7FFF;
  - the AXI register offset map shared with the register interface (coef base, commit, bypass).
- One sub-module, audio_fir_coef_bank: shadow/active register arrays, pending-commit flag and read port indexed by k.

Test Plan:
- Reset defaults: impulse 0x4000 followed by zeros, default coefficients -> outputs 0x4000 (rounding exact), then 0x0000. sample_valid_out occurs exactly NUM_TAPS+1 cycles after accept.
- Moving average: all 4 taps of a NUM_TAPS=4 build = 0x2000 (0.25), committed; steady input 0x1000 -> outputs ramp 0x0400, 0x0800, 0x0C00, 0x1000, then hold 0x1000.
- Commit during MAC: write tap0=0x4000 and pulse commit mid-sample -> the current output still uses 0x7FFF; the next sample uses 0x4000 (input 0x2000 -> 0x1000).
- Overflow: taps 0..3=0x7FFF, input 0x7FFF four times -> with AUDIO_FIR_SATURATE_EN, output 0x7FFF with sat_flag_out=1; without it, wrapped low 16 bits of the rounded result.
- Bypass: bypass_in=1 with input 0x8001 -> output 0x8001 at the same latency. Clearing bypass mid-stream -> history is continuous and matches a golden model.
- Handshake and reset: hold sample_valid_in high continuously -> one accept every NUM_TAPS+2 cycles. Assert rst_in mid-MAC -> no sample_valid_out, sample_ready_out=1 after release, history zeroed (impulse test repeats cleanly).
